// File: rtl/exe_stage_pkg.sv
// Shared constants and bundle layout for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD   = 137;
  localparam int ES_TO_MS_BUS_WD   = 71;
  localparam int ES_FWD_BLK_BUS_WD = 39;

  // Bit positions inside the one-hot alu_op field.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Decoded bundle from ID, MSB first; total width is DS_TO_ES_BUS_WD.
  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_uimm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with one-hot operation select; all-zero select gives 0.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] lui_res;

  // Every operation is computed in parallel; the one-hot select picks one.
  always_comb begin
    add_res  = alu_src1 + alu_src2;
    sub_res  = alu_src1 - alu_src2;
    slt_res  = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
    sltu_res = {31'b0, (alu_src1 < alu_src2)};
    sll_res  = alu_src2 << alu_src1[4:0];
    srl_res  = alu_src2 >> alu_src1[4:0];
    sra_res  = $unsigned($signed(alu_src2) >>> alu_src1[4:0]);
    lui_res  = {alu_src2[15:0], 16'b0};
  end

  // AND-OR select keeps an all-zero op vector producing a zero result.
  always_comb begin
    alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
               | ({32{alu_op[ALU_SUB]}}  & sub_res)
               | ({32{alu_op[ALU_SLT]}}  & slt_res)
               | ({32{alu_op[ALU_SLTU]}} & sltu_res)
               | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
               | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
               | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
               | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
               | ({32{alu_op[ALU_SLL]}}  & sll_res)
               | ({32{alu_op[ALU_SRL]}}  & srl_res)
               | ({32{alu_op[ALU_SRA]}}  & sra_res)
               | ({32{alu_op[ALU_LUI]}}  & lui_res);
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers the ID bundle, runs the ALU, drives the data
// SRAM request and reports forward/block information back to ID.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ms_allowin,
  output logic                         es_allowin,
  input  logic                         ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0]   ds_to_es_bus,
  output logic                         es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  output logic [ES_FWD_BLK_BUS_WD-1:0] es_fwd_blk_bus,
  output logic                         data_sram_en,
  output logic [3:0]                   data_sram_wen,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata
);

  logic          es_valid_q;
  logic          es_valid_d;
  ds_to_es_bus_t es_bus_q;
  ds_to_es_bus_t es_bus_d;
  logic          es_ready_go;
  logic [31:0]   alu_src1;
  logic [31:0]   alu_src2;
  logic [31:0]   alu_result;
  logic          dest_nz;

  // Single-cycle ALU: the stage is always ready to hand off.
  always_comb begin
    es_ready_go    = 1'b1;
    es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    es_to_ms_valid = es_valid_q && es_ready_go;
  end

  // Valid follows ID whenever we can accept; the bundle only loads on a fire.
  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      es_bus_d = ds_to_es_bus_t'(ds_to_es_bus);
    end
  end

  // Stage registers; reset drops any held instruction immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
    end
  end

  // Operand select, first matching source wins.
  always_comb begin
    alu_src1 = es_bus_q.rs_value;
    if (es_bus_q.src1_is_sa) begin
      alu_src1 = {27'b0, es_bus_q.imm[10:6]};
    end else if (es_bus_q.src1_is_pc) begin
      alu_src1 = es_bus_q.pc;
    end

    alu_src2 = es_bus_q.rt_value;
    if (es_bus_q.src2_is_imm) begin
      alu_src2 = {{16{es_bus_q.imm[15]}}, es_bus_q.imm};
    end else if (es_bus_q.src2_is_uimm) begin
      alu_src2 = {16'b0, es_bus_q.imm};
    end else if (es_bus_q.src2_is_8) begin
      alu_src2 = 32'd8;
    end
  end

  exe_stage_alu u_alu (
    .alu_op     (es_bus_q.alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // SRAM request is gated by ms_allowin so a stalled access is never reissued.
  always_comb begin
    data_sram_en    = es_valid_q && (es_bus_q.load_op || es_bus_q.mem_we) && ms_allowin;
    data_sram_wen   = {4{es_valid_q && es_bus_q.mem_we && ms_allowin}};
    data_sram_addr  = alu_result;
    data_sram_wdata = es_bus_q.rt_value;
  end

  // ID compares dest without a zero check, so dest 0 must never forward/block.
  always_comb begin
    dest_nz        = (es_bus_q.dest != 5'd0);
    es_fwd_blk_bus = {es_valid_q && es_bus_q.gr_we && !es_bus_q.load_op && dest_nz,
                      es_bus_q.dest,
                      alu_result,
                      es_valid_q && es_bus_q.load_op && es_bus_q.gr_we && dest_nz};
    es_to_ms_bus   = {es_bus_q.load_op,
                      es_bus_q.gr_we,
                      es_bus_q.dest,
                      alu_result,
                      es_bus_q.pc};
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage with a behavioural reference.
module tb_exe_stage;

  logic         clk;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [136:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_blk_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_checks;
  int n_fail;
  int store_cnt;

  // reference state: what the stage is holding
  logic         m_valid;
  logic [136:0] m_bus;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_blk_bus  (es_fwd_blk_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_sram_en && data_sram_wen == 4'hf) store_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // op: 0..11 picks that operation, anything else means no operation
  function automatic logic [136:0] mk_bus(input int op, input logic load, input logic sa,
                                          input logic ispc, input logic simm, input logic uimm,
                                          input logic is8, input logic gr_we, input logic mem_we,
                                          input logic [4:0] dest, input logic [15:0] imm,
                                          input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [31:0] pc);
    logic [11:0] oh;
    oh = 12'd0;
    if (op >= 0 && op < 12) oh = 12'd1 << op;
    return {oh, load, sa, ispc, simm, uimm, is8, gr_we, mem_we, dest, imm, rs, rt, pc};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sel;
    int sa_i;
    int sb_i;
    int sh;
    logic [31:0] r;
    sel = -1;
    for (int i = 0; i < 12; i++) if (op[i]) sel = i;
    sa_i = a;
    sb_i = b;
    sh = int'(a % 32);
    r = 32'd0;
    case (sel)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = (sa_i < sb_i) ? 32'd1 : 32'd0;
      3:  r = (a < b) ? 32'd1 : 32'd0;
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = b << sh;
      9:  r = b >> sh;
      10: begin
        r = b >> sh;
        if (b[31]) r = r | ~(32'hffffffff >> sh);
      end
      11: r = b * 32'd65536;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Compare every output against the reference state and current ms_allowin.
  task automatic check_outputs();
    logic [11:0] op;
    logic        load, sa, ispc, simm, uimm, is8, gr_we, mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs, rt, pc, s1, s2, res;
    {op, load, sa, ispc, simm, uimm, is8, gr_we, mem_we, dest, imm, rs, rt, pc} = m_bus;
    s1 = sa ? {27'd0, imm[10:6]} : (ispc ? pc : rs);
    s2 = simm ? {{16{imm[15]}}, imm} : (uimm ? {16'd0, imm} : (is8 ? 32'd8 : rt));
    res = ref_alu(op, s1, s2);
    check("es_allowin", es_allowin, !m_valid || ms_allowin);
    check("es_to_ms_valid", es_to_ms_valid, m_valid);
    check("es_to_ms_bus", es_to_ms_bus, {load, gr_we, dest, res, pc});
    check("es_fwd_blk_bus", es_fwd_blk_bus,
          {m_valid && gr_we && !load && dest != 0, dest, res,
           m_valid && load && gr_we && dest != 0});
    check("data_sram_en", data_sram_en, m_valid && (load || mem_we) && ms_allowin);
    check("data_sram_wen", data_sram_wen, (m_valid && mem_we && ms_allowin) ? 4'hf : 4'h0);
    check("data_sram_addr", data_sram_addr, res);
    check("data_sram_wdata", data_sram_wdata, rt);
  endtask

  // One cycle: drive at negedge, check, then advance the reference across posedge.
  task automatic drive(input logic v, input logic [136:0] b, input logic ms);
    @(negedge clk);
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = ms;
    #1;
    check_outputs();
    if (!m_valid || ms) begin
      m_valid = v;
      if (v) m_bus = b;
    end
  endtask

  logic [136:0] rb;
  logic [136:0] nop_bus;

  initial begin
    n_checks = 0;
    n_fail = 0;
    store_cnt = 0;
    m_valid = 1'b0;
    m_bus = '0;
    nop_bus = '0;
    resetn = 1'b0;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    #12;
    check("reset_valid", es_to_ms_valid, 1'b0);
    check("reset_sram_en", data_sram_en, 1'b0);
    check("reset_fwd_blk", {es_fwd_blk_bus[38], es_fwd_blk_bus[0]}, 2'b00);
    @(negedge clk);
    resetn = 1'b1;

    // addiu r2,r1,-1 with rs=5
    drive(1'b1, mk_bus(0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd2, 16'hffff, 32'd5, 32'd0, 32'hbfc00000), 1'b1);
    drive(1'b0, nop_bus, 1'b1);
    check("addiu_res", es_to_ms_bus[63:32], 32'd4);
    check("addiu_fwd", es_fwd_blk_bus[38], 1'b1);
    check("addiu_dest", es_fwd_blk_bus[37:33], 5'd2);
    check("addiu_en", data_sram_en, 1'b0);

    // lw r3,8(r1) with rs=0x1000
    drive(1'b1, mk_bus(0, 1, 0, 0, 1, 0, 0, 1, 0, 5'd3, 16'h0008, 32'h1000, 32'd0, 32'hbfc00004), 1'b1);
    drive(1'b0, nop_bus, 1'b1);
    check("lw_en", data_sram_en, 1'b1);
    check("lw_wen", data_sram_wen, 4'h0);
    check("lw_addr", data_sram_addr, 32'h1008);
    check("lw_blk", es_fwd_blk_bus[0], 1'b1);
    check("lw_fwd", es_fwd_blk_bus[38], 1'b0);
    check("lw_res_from_mem", es_to_ms_bus[70], 1'b1);

    // sw, then stalled 3 cycles before MEM accepts
    drive(1'b1, mk_bus(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd0, 16'hfffc, 32'h2000, 32'hdeadbeef, 32'hbfc00008), 1'b1);
    store_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk_bus(6, 0, 0, 0, 0, 0, 0, 1, 0, 5'd9, 16'h0, 32'h1, 32'h2, 32'h0), 1'b0);
      check("sw_stall_en", data_sram_en, 1'b0);
      check("sw_stall_allowin", es_allowin, 1'b0);
      check("sw_stall_addr", data_sram_addr, 32'h1ffc);
    end
    drive(1'b0, nop_bus, 1'b1);
    check("sw_addr", data_sram_addr, 32'h1ffc);
    check("sw_wen", data_sram_wen, 4'hf);
    check("sw_wdata", data_sram_wdata, 32'hdeadbeef);
    drive(1'b0, nop_bus, 1'b1);
    check("sw_single_issue", store_cnt, 1);

    // jal, sra, lui back to back
    drive(1'b1, mk_bus(0, 0, 0, 1, 0, 0, 1, 1, 0, 5'd31, 16'h0, 32'h0, 32'h0, 32'hbfc00010), 1'b1);
    drive(1'b1, mk_bus(10, 0, 1, 0, 0, 0, 0, 1, 0, 5'd4, 16'h0100, 32'h0, 32'h80000000, 32'h0), 1'b1);
    check("jal_res", es_to_ms_bus[63:32], 32'hbfc00018);
    drive(1'b1, mk_bus(11, 0, 0, 0, 0, 1, 0, 1, 0, 5'd5, 16'h1234, 32'h0, 32'h0, 32'h0), 1'b1);
    check("sra_res", es_to_ms_bus[63:32], 32'hf8000000);
    drive(1'b1, mk_bus(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 16'h0, 32'h3, 32'h4, 32'h0), 1'b1);
    check("lui_res", es_to_ms_bus[63:32], 32'h12340000);
    drive(1'b1, mk_bus(0, 1, 0, 0, 1, 0, 0, 1, 0, 5'd0, 16'h4, 32'h100, 32'h0, 32'h0), 1'b1);
    check("addu_r0_fwd", es_fwd_blk_bus[38], 1'b0);
    check("addu_r0_blk", es_fwd_blk_bus[0], 1'b0);
    drive(1'b0, nop_bus, 1'b1);
    check("lw_r0_blk", es_fwd_blk_bus[0], 1'b0);

    // randomized traffic against the reference
    for (int n = 0; n < 2000; n++) begin
      rb = mk_bus(int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom), 16'($urandom), $urandom, $urandom, $urandom);
      drive(1'($urandom), rb, ($urandom_range(0, 3) != 0));
    end

    // async reset while a store is stalled
    drive(1'b1, mk_bus(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd0, 16'h10, 32'h3000, 32'h55aa55aa, 32'h0), 1'b1);
    drive(1'b0, nop_bus, 1'b0);
    check("pre_reset_valid", es_to_ms_valid, 1'b1);
    #2;
    resetn = 1'b0;
    ms_allowin = 1'b1;
    #1;
    check("arst_valid", es_to_ms_valid, 1'b0);
    check("arst_sram_en", data_sram_en, 1'b0);
    check("arst_wen", data_sram_wen, 4'h0);
    check("arst_fwd_blk", {es_fwd_blk_bus[38], es_fwd_blk_bus[0]}, 2'b00);
    m_valid = 1'b0;
    m_bus = '0;
    @(posedge clk);
    #1;
    check("arst_hold_en", data_sram_en, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, mk_bus(0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd2, 16'hffff, 32'd5, 32'd0, 32'h0), 1'b1);
    drive(1'b0, nop_bus, 1'b1);
    check("post_reset_res", es_to_ms_bus[63:32], 32'd4);
    check("post_reset_valid", es_to_ms_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
